ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 68 ++++++
 rtl/ifetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_ifetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//
// Bundles every non-clock/non-reset signal of the instruction fetch unit:
//   - instruction-memory bus : imem_req, imem_addr (fetch side drives),
//                              imem_ack, imem_rdata (memory drives)
//   - decode-side handshake  : instr, instr_valid, pc_out (fetch side drives),
//                              instr_ready (decode drives)
//   - redirect inputs        : branch, jump, jr, zero, rs_data (decode/ALU
//                              drive; sampled only when an instruction is
//                              consumed)
//
// Modports:
//   master - the fetch unit itself
//   slave  - the environment (memory + decode stage)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    // instruction-memory read bus
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // fetched instruction towards decode
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;

    // control flags and jr source for the held instruction
    logic        branch;
    logic        jump;
    logic        jr;
    logic        zero;
    logic [31:0] rs_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  instr_ready,
        output pc_out,
        input  branch,
        input  jump,
        input  jr,
        input  zero,
        input  rs_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready,
        input  pc_out,
        output branch,
        output jump,
        output jr,
        output zero,
        output rs_data
    );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Single-issue instruction fetch unit. Holds the program counter, issues one
// read to instruction memory at a time, holds the returned word for the
// decode stage and, when decode consumes it, computes the next PC from the
// decode/ALU flags (jr, jump, taken branch or sequential).
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - ifetch_unit_if.master (memory bus, decode handshake,
//                  redirect flags)
//   redirect_cnt - [optional] 16-bit saturating count of accepted
//                  instructions whose successor was not PC+4
//
// Parameters:
//   RESET_PC     - PC loaded on reset (first fetch address)
//
// Build options:
//   IFETCH_REDIRECT_CNT_EN - when defined, adds the redirect_cnt output and
//                            its counter; otherwise the port is absent.
//
// Sequencing: IDLE -> REQ (unconditional), REQ -> HOLD on imem_ack,
// HOLD -> REQ when instr_ready. imem_req is high exactly in REQ, instr_valid
// exactly in HOLD; both are registered alongside the state.
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
`ifdef IFETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0]   redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        req_reg;
    logic        valid_reg;

    // Reset is asserted asynchronously but released through this flop, so
    // the FSM sits in IDLE for the first edge after rst_n rises and the
    // first request appears on the second edge.
    logic        run_reg;

    // ------------------------------------------------------------------
    // Next-PC computation (combinational from held instruction + flags)
    // ------------------------------------------------------------------
    logic [31:0] pc4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] next_pc;
    logic        accept;

    assign pc4         = pc_reg + 32'd4;
    // sign-extended word offset, already scaled by 4
    assign br_offset   = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign br_target   = pc4 + br_offset;
    assign jump_target = {pc4[31:28], instr_reg[25:0], 2'b00};
    assign jr_target   = {bus.rs_data[31:2], 2'b00};

    // rs_data[1:0] is discarded to keep the jr target word aligned
    logic unused_rs_low;
    assign unused_rs_low = ^bus.rs_data[1:0];

    // jr beats jump beats taken branch; a jump with branch also set must
    // still jump, which this ordering guarantees.
    always_comb begin
        next_pc = pc4;
        if (bus.jr) begin
            next_pc = jr_target;
        end else if (bus.jump) begin
            next_pc = jump_target;
        end else if (bus.branch && bus.zero) begin
            next_pc = br_target;
        end
    end

    // Flags only matter on this condition; in every other cycle they are
    // ignored because nothing below looks at next_pc outside an accept.
    assign accept = (state_reg == HOLD) && bus.instr_ready;

    // ------------------------------------------------------------------
    // Reset release
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else if (!run_reg) begin
            // first edge after reset release: stay in the reset state
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
            req_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= REQ;
                    req_reg   <= 1'b1;
                    valid_reg <= 1'b0;
                end
                REQ: begin
                    // pc_reg is untouched here, so imem_addr is stable
                    // for as long as the ack is withheld
                    if (bus.imem_ack) begin
                        instr_reg <= bus.imem_rdata;
                        state_reg <= HOLD;
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    // imem_ack is not looked at here: a stray ack is dropped
                    if (bus.instr_ready) begin
                        pc_reg    <= next_pc;
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = pc_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.pc_out      = pc_reg;

`ifdef IFETCH_REDIRECT_CNT_EN
    // ------------------------------------------------------------------
    // Redirect counter: counts accepts whose successor is not PC+4
    // ------------------------------------------------------------------
    logic [15:0] redirect_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_reg <= 16'd0;
        end else if (accept && (next_pc != pc4) && (redirect_cnt_reg != 16'hFFFF)) begin
            redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_reg;
`else
    // accept only feeds the optional counter
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Drives ifetch_unit through directed scenarios and a long randomized run.
// A transaction-level model (phase: booting / waiting for memory / holding
// an instruction, plus PC, held word and redirect count) predicts the
// outputs; one compare process checks the DUT against it on every falling
// edge, and a few hand-computed literals pin the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int PH_BOOT  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_HOLD  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch_unit_if bus ();

`ifdef IFETCH_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef IFETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // model state
    int          m_phase;
    int          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_cnt;
    bit          chk_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic br, input logic jmp, input logic jrr,
                                               input logic zr, input logic [31:0] rs);
        logic [31:0] seq;
        logic [31:0] off;
        seq = pc + 32'd4;
        off = {{16{ins[15]}}, ins[15:0]};
        if (jrr) return rs & 32'hFFFF_FFFC;
        if (jmp) return {seq[31:28], ins[25:0], 2'b00};
        if (br && zr) return seq + off * 32'd4;
        return seq;
    endfunction

    // one clock edge with the given inputs; the model advances with it
    task automatic tick(input logic ack, input logic [31:0] rdata, input logic ready,
                        input logic br, input logic jmp, input logic jrr, input logic zr,
                        input logic [31:0] rs);
        logic [31:0] np;
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.instr_ready = ready;
        bus.branch      = br;
        bus.jump        = jmp;
        bus.jr          = jrr;
        bus.zero        = zr;
        bus.rs_data     = rs;
        @(posedge clk);
        case (m_phase)
            PH_BOOT: begin
                m_boot--;
                if (m_boot == 0) m_phase = PH_FETCH;
            end
            PH_FETCH: begin
                if (ack) begin
                    m_instr = rdata;
                    m_phase = PH_HOLD;
                end
            end
            default: begin
                if (ready) begin
                    np = model_next(m_pc, m_instr, br, jmp, jrr, zr, rs);
                    if (np != m_pc + 32'd4 && m_cnt != 16'hFFFF) m_cnt++;
                    m_pc    = np;
                    m_phase = PH_FETCH;
                end
            end
        endcase
        #1;
    endtask

    task automatic idle_tick();
        tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // asserts reset asynchronously mid-cycle, checks, then releases it
    task automatic do_reset();
        bus.imem_ack = 1'b1;   // a pending ack that must be discarded
        rst_n = 1'b0;
        #1;
        m_phase = PH_BOOT;
        m_boot  = 2;
        m_pc    = RESET_PC;
        m_instr = 32'd0;
        m_cnt   = 16'd0;
        check32("rst_req",   {31'd0, bus.imem_req},    32'd0);
        check32("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check32("rst_instr", bus.instr,                32'd0);
        check32("rst_pc",    bus.pc_out,               RESET_PC);
`ifdef IFETCH_REDIRECT_CNT_EN
        check32("rst_cnt",   {16'd0, redirect_cnt},    32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    // advance to a pending request, then ack it with the given word
    task automatic fetch_word(input logic [31:0] data);
        for (int i = 0; i < 4 && m_phase != PH_FETCH; i++) idle_tick();
        check32("reach_req", {31'd0, bus.imem_req}, 32'd1);
        tick(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic accept(input logic br, input logic jmp, input logic jrr,
                          input logic zr, input logic [31:0] rs);
        tick(1'b0, 32'd0, 1'b1, br, jmp, jrr, zr, rs);
    endtask

    // redirect the PC via jr from HOLD
    task automatic goto_pc(input logic [31:0] target);
        accept(1'b0, 1'b0, 1'b1, 1'b0, target);
    endtask

    // ------------------------------------------------------------------
    // Compare process: DUT vs model on every falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check32("imem_req",    {31'd0, bus.imem_req},    {31'd0, m_phase == PH_FETCH});
            check32("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_phase == PH_HOLD});
            check32("instr",       bus.instr,                m_instr);
            if (m_phase == PH_FETCH) check32("imem_addr", bus.imem_addr, m_pc);
            if (m_phase == PH_HOLD)  check32("pc_out",    bus.pc_out,    m_pc);
`ifdef IFETCH_REDIRECT_CNT_EN
            check32("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, m_cnt});
`endif
        end
    end

    initial begin
        logic [31:0] addr0;
        logic [15:0] cnt0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.instr_ready = 1'b0;
        bus.branch = 1'b0; bus.jump = 1'b0; bus.jr = 1'b0; bus.zero = 1'b0;
        bus.rs_data = 32'd0;
        #2;
        do_reset();
        chk_en = 1'b1;

        // first request appears on the second edge after release
        idle_tick();
        check32("boot_edge1_req", {31'd0, bus.imem_req}, 32'd0);
        idle_tick();
        check32("boot_edge2_req", {31'd0, bus.imem_req}, 32'd1);
        check32("boot_addr", bus.imem_addr, RESET_PC);

        // ack in the first REQ cycle
        tick(1'b1, 32'h8C08_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check32("t33_valid", {31'd0, bus.instr_valid}, 32'd1);
        check32("t33_instr", bus.instr, 32'h8C08_0004);
        check32("t33_pc", bus.pc_out, 32'h0);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check32("t33_next", bus.imem_addr, 32'h4);

        // taken and untaken backward branch at 0x40
        fetch_word(32'h0000_0000);
        goto_pc(32'h40);
        fetch_word(32'h1109_FFFE);
        accept(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        check32("t34_taken", bus.imem_addr, 32'h3C);
        fetch_word(32'h0000_0000);
        goto_pc(32'h40);
        fetch_word(32'h1109_FFFE);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check32("t34_nottaken", bus.imem_addr, 32'h44);

        // jump wins over branch
        fetch_word(32'h0000_0000);
        goto_pc(32'h1000_0010);
        fetch_word(32'h0800_0100);
        accept(1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
        check32("t35_jump", bus.imem_addr, 32'h1000_0400);

        // jr wins over jump; counter steps once
        fetch_word(32'h0800_0100);
`ifdef IFETCH_REDIRECT_CNT_EN
        cnt0 = redirect_cnt;
`else
        cnt0 = 16'd0;
`endif
        accept(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0123);
        check32("t36_jr", bus.imem_addr, 32'h0000_0120);
`ifdef IFETCH_REDIRECT_CNT_EN
        check32("t36_cnt", {16'd0, redirect_cnt}, {16'd0, cnt0 + 16'd1});
`else
        check32("t36_cnt_base", {16'd0, cnt0}, {16'd0, m_cnt - m_cnt});
`endif

        // ack withheld three cycles with instr_ready high
        addr0 = bus.imem_addr;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
            check32("t37_req",   {31'd0, bus.imem_req},    32'd1);
            check32("t37_addr",  bus.imem_addr,            addr0);
            check32("t37_valid", {31'd0, bus.instr_valid}, 32'd0);
        end

        // PC wraps modulo 2^32
        fetch_word(32'h0000_0000);
        goto_pc(32'hFFFF_FFFC);
        fetch_word(32'h0000_0000);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        check32("wrap_addr", bus.imem_addr, 32'h0);

        // reset while holding at 0x80
        fetch_word(32'h0000_0000);
        goto_pc(32'h80);
        fetch_word(32'h1234_5678);
        check32("t38_hold_pc", bus.pc_out, 32'h80);
        do_reset();
        idle_tick();
        idle_tick();
        check32("t38_refetch", bus.imem_addr, RESET_PC);

        // randomized run, occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 1) == 1, $urandom,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                     $urandom);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
